// File: rtl/reg_wb_if.sv
// reg_wb_if: writeback request, register-file write port and hazard-check signals
interface reg_wb_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_rd;
  logic [DW-1:0] req_data;
  logic          hold;
  logic          flush;
  logic          WE3;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;
  logic [AW-1:0] chk_a1;
  logic [AW-1:0] chk_a2;
  logic          pend1;
  logic          pend2;
  logic [DW-1:0] fwd1;
  logic [DW-1:0] fwd2;
  modport master (
    output req_valid, req_rd, req_data, hold, flush, chk_a1, chk_a2,
    input  req_ready, WE3, A3, WD3, pend1, pend2, fwd1, fwd2
  );
  modport slave (
    input  req_valid, req_rd, req_data, hold, flush, chk_a1, chk_a2,
    output req_ready, WE3, A3, WD3, pend1, pend2, fwd1, fwd2
  );
endinterface

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: in-order writeback queue feeding the register file write port, with pending/forward lookup
module reg_wb_queue #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic     clk,
  input logic     rst,
  reg_wb_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [AW-1:0] rd_q   [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop, push, nonempty;
  assign nonempty      = count_q != '0;
  // rst gates pop so nothing commits on the reset edge
  assign pop           = nonempty & ~bus.hold & ~bus.flush & ~rst;
  assign bus.req_ready = ~rst & ~bus.flush & ((count_q < FULL) | pop);
  assign push          = bus.req_valid & bus.req_ready & (bus.req_rd != '0);
  assign bus.WE3       = pop;
  assign bus.A3        = nonempty ? rd_q[rd_ptr_q] : '0;
  assign bus.WD3       = nonempty ? data_q[rd_ptr_q] : '0;
  // walks oldest to youngest so the youngest match wins
  function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
    logic [DW:0]   r;
    logic [PW-1:0] idx;
    r = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q && rd_q[idx] == a && a != '0) r = {1'b1, data_q[idx]};
    end
    return r;
  endfunction
  assign {bus.pend1, bus.fwd1} = lookup(bus.chk_a1);
  assign {bus.pend2, bus.fwd2} = lookup(bus.chk_a2);
  always_comb begin
    rd_ptr_d = bus.flush ? wr_ptr_q : rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = bus.flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) begin
        rd_q[wr_ptr_q]   <= bus.req_rd;
        data_q[wr_ptr_q] <= bus.req_data;
      end
    end
  end
endmodule
